// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared encodings for the program-counter generator.
//   - redirect_e : encoding of the redirect_type input (6 and 7 behave as none)
//   - state_e    : fetch sequencer states
//   - default reset and exception vectors
//   - is_target_redirect(): true for redirects that carry a target address
package pc_gen_pkg;

    typedef enum logic [2:0] {
        RD_NONE   = 3'd0,
        RD_BRANCH = 3'd1,
        RD_JUMP   = 3'd2,
        RD_JR     = 3'd3,
        RD_EXC    = 3'd4,
        RD_ERET   = 3'd5
    } redirect_e;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        EXC  = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0040_0004;

    // Branch, jump and jr are the only redirects whose target comes from redirect_target.
    function automatic logic is_target_redirect(input logic [2:0] rt);
        return (rt == RD_BRANCH) || (rt == RD_JUMP) || (rt == RD_JR);
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: circular return-address stack with a saturating count.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, pop       stack operations for this edge (both: replace top entry)
//   push_data       value written on push
//   top             top entry, 0 when the stack is empty
//   empty           stack holds no entries
// Pushing when full advances the pointer onto the oldest slot, so the oldest
// return address is silently overwritten and the count stays at RAS_DEPTH.
module ret_addr_stack
    import pc_gen_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] next_ptr_s;

    assign next_ptr_s = top_ptr_r + PTR_ONE;

    // Stack storage, top pointer and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_ptr_r <= {PTR_W{1'b0}};
            count_r   <= CNT_ZERO;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push && pop) begin
            // Return and call in one instruction: swap the top, depth unchanged.
            mem_r[top_ptr_r] <= push_data;
        end else if (push) begin
            mem_r[next_ptr_s] <= push_data;
            top_ptr_r         <= next_ptr_s;
            if (count_r != CNT_FULL) begin
                count_r <= count_r + CNT_ONE;
            end
        end else if (pop && (count_r != CNT_ZERO)) begin
            top_ptr_r <= top_ptr_r - PTR_ONE;
            count_r   <= count_r - CNT_ONE;
        end
    end

    assign empty = (count_r == CNT_ZERO);
    assign top   = empty ? {WIDTH{1'b0}} : mem_r[top_ptr_r];

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with exception/eret handling and a
// return-address stack for call/return prediction.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ena               global enable; 0 freezes all state
//   stall             hold the pc
//   fetch_ready       instruction memory accepts pc this cycle
//   pc, pc_valid      registered fetch request
//   redirect_type     0 none, 1 branch, 2 jump, 3 jr, 4 exception, 5 eret
//   redirect_target   target for types 1-3
//   call, ras_pop     push pc+INSTR_BYTES on aligned jump/jr; pop the stack
//   ras_top, ras_empty  return-address stack view
//   epc, bad_addr     exception pc and last misaligned target
//   addr_err          one-cycle pulse on a misaligned target
// All outputs come from registers; inputs only influence the next edge.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
    parameter int                 INSTR_BYTES  = 4,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             stall,
    input  logic             fetch_ready,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    input  logic [2:0]       redirect_type,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             call,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] bad_addr,
    output logic             addr_err
);

    localparam logic [WIDTH-1:0] STEP  = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};

    state_e           state_r;
    logic [WIDTH-1:0] pc_r;
    logic             pc_valid_r;
    logic [WIDTH-1:0] epc_r;
    logic [WIDTH-1:0] bad_addr_r;
    logic             addr_err_r;

    logic             target_redir_s;
    logic             misaligned_s;
    logic             run_edge_s;
    logic             ras_push_s;
    logic             ras_pop_s;
    logic [WIDTH-1:0] seq_pc_s;

    assign target_redir_s = is_target_redirect(redirect_type);
    assign misaligned_s   = (redirect_target % STEP) != ZERO;
    assign run_edge_s     = ena && (state_r == RUN);
    assign seq_pc_s       = pc_r + STEP;

    // Only a successfully taken jal/jalr records a return address; a
    // misaligned call traps instead, so nothing is pushed.
    assign ras_push_s = run_edge_s && call && !misaligned_s
                        && ((redirect_type == RD_JUMP) || (redirect_type == RD_JR));
    assign ras_pop_s  = ena && ras_pop;

    // Fetch sequencer: state, pc and the exception bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= BOOT;
            pc_r       <= RESET_VECTOR;
            pc_valid_r <= 1'b0;
            epc_r      <= ZERO;
            bad_addr_r <= ZERO;
            addr_err_r <= 1'b0;
        end else if (!ena) begin
            addr_err_r <= 1'b0;
        end else begin
            addr_err_r <= 1'b0;
            case (state_r)
                BOOT: begin
                    state_r    <= RUN;
                    pc_valid_r <= 1'b1;
                end
                RUN: begin
                    if (redirect_type == RD_EXC) begin
                        pc_r       <= EXC_VECTOR;
                        epc_r      <= pc_r;
                        state_r    <= EXC;
                        pc_valid_r <= 1'b0;
                    end else if (redirect_type == RD_ERET) begin
                        pc_r <= epc_r;
                    end else if (target_redir_s) begin
                        if (misaligned_s) begin
                            pc_r       <= EXC_VECTOR;
                            epc_r      <= pc_r;
                            bad_addr_r <= redirect_target;
                            addr_err_r <= 1'b1;
                            state_r    <= EXC;
                            pc_valid_r <= 1'b0;
                        end else begin
                            pc_r <= redirect_target;
                        end
                    end else if (stall || !fetch_ready) begin
                        pc_r <= pc_r;
                    end else begin
                        // Natural modulo-2^WIDTH wrap is intended.
                        pc_r <= seq_pc_s;
                    end
                end
                EXC: begin
                    state_r    <= RUN;
                    pc_valid_r <= 1'b1;
                end
                default: begin
                    state_r    <= BOOT;
                    pc_valid_r <= 1'b0;
                end
            endcase
        end
    end

    ret_addr_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (seq_pc_s),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    assign pc       = pc_r;
    assign pc_valid = pc_valid_r;
    assign epc      = epc_r;
    assign bad_addr = bad_addr_r;
    assign addr_err = addr_err_r;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] EV = 32'h0040_0004;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        stall;
    logic        fetch_ready;
    logic [31:0] pc;
    logic        pc_valid;
    logic [2:0]  redirect_type;
    logic [31:0] redirect_target;
    logic        call;
    logic        ras_pop;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic [31:0] epc;
    logic [31:0] bad_addr;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    pc_gen dut (
        .clk             (clk),
        .rst             (rst),
        .ena             (ena),
        .stall           (stall),
        .fetch_ready     (fetch_ready),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .redirect_type   (redirect_type),
        .redirect_target (redirect_target),
        .call            (call),
        .ras_pop         (ras_pop),
        .ras_top         (ras_top),
        .ras_empty       (ras_empty),
        .epc             (epc),
        .bad_addr        (bad_addr),
        .addr_err        (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 boot, 1 running, 2 exception bubble
    int          m_mode;
    logic [31:0] m_pc, m_epc, m_bad;
    logic        m_err;
    logic [31:0] m_ras[$];

    task automatic model_reset();
        m_mode = 0; m_pc = RV; m_epc = 32'h0; m_bad = 32'h0; m_err = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_edge(input logic e, s, f, input logic [2:0] rt,
                              input logic [31:0] tgt, input logic c, p);
        logic [31:0] ret_addr;
        logic        do_push;
        ret_addr = m_pc + 32'd4;
        do_push  = 1'b0;
        m_err    = 1'b0;
        if (e) begin
            if (m_mode != 1) begin
                m_mode = 1;
            end else if (rt == 3'd4) begin
                m_epc = m_pc; m_pc = EV; m_mode = 2;
            end else if (rt == 3'd5) begin
                m_pc = m_epc;
            end else if (rt >= 3'd1 && rt <= 3'd3) begin
                if (tgt % 32'd4 != 32'd0) begin
                    m_epc = m_pc; m_bad = tgt; m_pc = EV; m_err = 1'b1; m_mode = 2;
                end else begin
                    m_pc = tgt;
                    do_push = c && (rt != 3'd1);
                end
            end else if (!s && f) begin
                m_pc = m_pc + 32'd4;
            end
            if (do_push && p) begin
                if (m_ras.size() > 0) m_ras[m_ras.size()-1] = ret_addr;
            end else if (do_push) begin
                m_ras.push_back(ret_addr);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end else if (p && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, (m_mode == 1)});
        check({tag, ".epc"}, epc, m_epc);
        check({tag, ".bad_addr"}, bad_addr, m_bad);
        check({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, m_err});
        check({tag, ".ras_top"}, ras_top, (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0);
        check({tag, ".ras_empty"}, {31'd0, ras_empty}, {31'd0, (m_ras.size() == 0)});
    endtask

    // Drive one cycle of inputs, let one edge pass, then compare against the model.
    task automatic step(input string tag, input logic e, s, f, input logic [2:0] rt,
                        input logic [31:0] tgt, input logic c, p);
        ena = e; stall = s; fetch_ready = f; redirect_type = rt;
        redirect_target = tgt; call = c; ras_pop = p;
        @(posedge clk); #1;
        model_edge(e, s, f, rt, tgt, c, p);
        compare_model(tag);
    endtask

    typedef struct {
        logic        e, s, f;
        logic [2:0]  rt;
        logic [31:0] tgt;
        logic [31:0] x_pc;
        logic        x_valid, x_err;
        logic [31:0] x_epc, x_bad;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic e, s, f, input logic [2:0] rt, input logic [31:0] tgt,
                                input logic [31:0] xp, input logic xv, xe,
                                input logic [31:0] xepc, xbad);
        vec_t v;
        v.e = e; v.s = s; v.f = f; v.rt = rt; v.tgt = tgt;
        v.x_pc = xp; v.x_valid = xv; v.x_err = xe; v.x_epc = xepc; v.x_bad = xbad;
        return v;
    endfunction

    logic [31:0] pop_tops[5];
    logic [31:0] rtgt;

    initial begin
        rst = 1'b1; ena = 1'b1; stall = 1'b0; fetch_ready = 1'b1;
        redirect_type = 3'd0; redirect_target = 32'h0; call = 1'b0; ras_pop = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        compare_model("reset");
        rst = 1'b0;

        // Sequential run after reset: one BOOT cycle, then incrementing fetch.
        step("boot", 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0);
        check("boot.pc", pc, 32'h0040_0000);
        step("seq1", 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0);
        check("seq1.pc", pc, 32'h0040_0004);
        step("seq2", 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0);
        check("seq2.pc", pc, 32'h0040_0008);

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        #3 rst = 1'b1;
        #1;
        check("async_rst.pc", pc, RV);
        check("async_rst.pc_valid", {31'd0, pc_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        compare_model("post_rst");

        // Directed table: run, hold, ena freeze, redirect over stall, misaligned jr, eret.
        vecs[0]  = mk(1,0,1,3'd0,32'h0,        32'h0040_0000,1,0,32'h0,        32'h0);
        vecs[1]  = mk(1,0,1,3'd0,32'h0,        32'h0040_0004,1,0,32'h0,        32'h0);
        vecs[2]  = mk(1,0,1,3'd0,32'h0,        32'h0040_0008,1,0,32'h0,        32'h0);
        vecs[3]  = mk(1,0,1,3'd0,32'h0,        32'h0040_000C,1,0,32'h0,        32'h0);
        vecs[4]  = mk(1,0,1,3'd0,32'h0,        32'h0040_0010,1,0,32'h0,        32'h0);
        vecs[5]  = mk(1,1,1,3'd0,32'h0,        32'h0040_0010,1,0,32'h0,        32'h0);
        vecs[6]  = mk(1,1,1,3'd0,32'h0,        32'h0040_0010,1,0,32'h0,        32'h0);
        vecs[7]  = mk(1,0,0,3'd0,32'h0,        32'h0040_0010,1,0,32'h0,        32'h0);
        vecs[8]  = mk(0,0,1,3'd2,32'h0040_0100,32'h0040_0010,1,0,32'h0,        32'h0);
        vecs[9]  = mk(1,1,1,3'd1,32'h0040_0040,32'h0040_0040,1,0,32'h0,        32'h0);
        vecs[10] = mk(1,0,1,3'd2,32'h0040_0020,32'h0040_0020,1,0,32'h0,        32'h0);
        vecs[11] = mk(1,0,1,3'd3,32'h0040_0102,32'h0040_0004,0,1,32'h0040_0020,32'h0040_0102);
        vecs[12] = mk(1,1,1,3'd0,32'h0,        32'h0040_0004,1,0,32'h0040_0020,32'h0040_0102);
        vecs[13] = mk(1,0,1,3'd5,32'h0,        32'h0040_0020,1,0,32'h0040_0020,32'h0040_0102);
        vecs[14] = mk(1,0,1,3'd0,32'h0,        32'h0040_0024,1,0,32'h0040_0020,32'h0040_0102);
        for (int i = 0; i < 15; i++) begin
            step($sformatf("vec%0d", i), vecs[i].e, vecs[i].s, vecs[i].f, vecs[i].rt,
                 vecs[i].tgt, 1'b0, 1'b0);
            check($sformatf("vec%0d.pc", i), pc, vecs[i].x_pc);
            check($sformatf("vec%0d.pc_valid", i), {31'd0, pc_valid}, {31'd0, vecs[i].x_valid});
            check($sformatf("vec%0d.addr_err", i), {31'd0, addr_err}, {31'd0, vecs[i].x_err});
            check($sformatf("vec%0d.epc", i), epc, vecs[i].x_epc);
            check($sformatf("vec%0d.bad_addr", i), bad_addr, vecs[i].x_bad);
        end

        // RAS overflow: five calls from A..E, the oldest (A+4) is overwritten.
        step("jmpA", 1'b1, 1'b0, 1'b1, 3'd2, 32'h0040_1000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("call%0d", i), 1'b1, 1'b0, 1'b1, (i % 2 == 0) ? 3'd2 : 3'd3,
                 32'h0040_2000 + 32'h1000 * i, 1'b1, 1'b0);
            check($sformatf("call%0d.ras_top", i), ras_top, 32'h0040_1004 + 32'h1000 * i);
        end
        pop_tops[0] = 32'h0040_4004; pop_tops[1] = 32'h0040_3004; pop_tops[2] = 32'h0040_2004;
        pop_tops[3] = 32'h0;         pop_tops[4] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("pop%0d", i), 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b1);
            check($sformatf("pop%0d.ras_top", i), ras_top, pop_tops[i]);
            check($sformatf("pop%0d.ras_empty", i), {31'd0, ras_empty}, (i >= 3) ? 32'd1 : 32'd0);
        end

        // A misaligned call traps and pushes nothing.
        step("badcall", 1'b1, 1'b0, 1'b1, 3'd2, 32'h0040_6002, 1'b1, 1'b0);
        check("badcall.ras_empty", {31'd0, ras_empty}, 32'd1);
        step("badcall_bubble", 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0);

        // Two pushes, exception/eret leave RAS intact, then push+pop swaps the top.
        step("jmpG", 1'b1, 1'b0, 1'b1, 3'd2, 32'h0040_7000, 1'b0, 1'b0);
        step("callG", 1'b1, 1'b0, 1'b1, 3'd2, 32'h0040_8000, 1'b1, 1'b0);
        step("callH", 1'b1, 1'b0, 1'b1, 3'd3, 32'h0040_9000, 1'b1, 1'b0);
        step("exc", 1'b1, 1'b0, 1'b1, 3'd4, 32'h0, 1'b0, 1'b0);
        check("exc.pc", pc, EV);
        check("exc.epc", epc, 32'h0040_9000);
        check("exc.ras_top", ras_top, 32'h0040_8004);
        step("exc_bubble", 1'b1, 1'b0, 1'b1, 3'd5, 32'h0, 1'b0, 1'b0);
        check("exc_bubble.pc", pc, EV);
        step("eret", 1'b1, 1'b0, 1'b1, 3'd5, 32'h0, 1'b0, 1'b0);
        check("eret.pc", pc, 32'h0040_9000);
        check("eret.ras_top", ras_top, 32'h0040_8004);
        step("pushpop", 1'b1, 1'b0, 1'b1, 3'd2, 32'h0040_A000, 1'b1, 1'b1);
        check("pushpop.ras_top", ras_top, 32'h0040_9004);
        step("pp_pop1", 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b1);
        check("pp_pop1.ras_top", ras_top, 32'h0040_7004);
        step("pp_pop2", 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b1);
        check("pp_pop2.ras_empty", {31'd0, ras_empty}, 32'd1);

        // pc wraps to zero at the top of the address space.
        step("jmp_top", 1'b1, 1'b0, 1'b1, 3'd1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step("wrap", 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0);
        check("wrap.pc", pc, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rtgt = $urandom();
            if ($urandom_range(0, 3) != 0) rtgt[1:0] = 2'b00;
            step($sformatf("rand%0d", i),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)),
                 rtgt,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
